wb_arbiter: RTL



---
 rtl/decode_pkg.sv | 10 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/wb_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared decode-stage constants: default widths and result-source indices.
package decode_pkg;
    localparam int NUM_SRC = 3;
    localparam int REG_AW  = 5;
    localparam int DATA_W  = 32;

    localparam int SRC_ALU = 0;
    localparam int SRC_MUL = 1;
    localparam int SRC_FPU = 2;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past the winner on advance.
module rr_arbiter import decode_pkg::*; #(
    parameter int NUM_SRC = decode_pkg::NUM_SRC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic               advance,
    output logic [NUM_SRC-1:0] gnt
);
    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;

    always_comb begin : sel
        int  idx;
        logic found;
        gnt     = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(ptr) + k) % NUM_SRC;
            // Grant is masked while in reset so nothing is accepted during it.
            if (rst && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
                ptr_nxt  = PW'((idx + 1) % NUM_SRC);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr <= '0;
        else if (advance)
            ptr <= ptr_nxt;
    end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin grant of one result per cycle onto the registered
// register-file write port, plus per-bank pending scoreboard driving the decode stall.
module wb_arbiter import decode_pkg::*; #(
    parameter int DATA_W  = decode_pkg::DATA_W,
    parameter int REG_AW  = decode_pkg::REG_AW,
    parameter int NUM_SRC = decode_pkg::NUM_SRC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*REG_AW-1:0] src_rd,
    input  logic [NUM_SRC-1:0]        src_fp,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [REG_AW-1:0]         write_reg,
    output logic [DATA_W-1:0]         write_data,
    output logic                      reg_write_i,
    output logic                      FPR_GPR_sel,
    input  logic                      issue_valid,
    input  logic [REG_AW-1:0]         issue_rd,
    input  logic                      issue_fp,
    input  logic [REG_AW-1:0]         rs1,
    input  logic [REG_AW-1:0]         rs2,
    input  logic                      rs1_fp,
    input  logic                      rs2_fp,
    input  logic [REG_AW-1:0]         rd_chk,
    input  logic                      rd_chk_fp,
    output logic                      stall
);
    localparam int NREG = 1 << REG_AW;

    logic [NUM_SRC-1:0] gnt;
    logic               accept;
    logic [REG_AW-1:0]  win_rd;
    logic [DATA_W-1:0]  win_data;
    logic               win_fp;
    logic               win_x0;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (src_valid),
        .advance (accept),
        .gnt     (gnt)
    );

    assign src_ready = gnt;
    assign accept    = |gnt;

    always_comb begin
        win_rd   = '0;
        win_data = '0;
        win_fp   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt[i]) begin
                win_rd   = src_rd[i*REG_AW +: REG_AW];
                win_data = src_data[i*DATA_W +: DATA_W];
                win_fp   = src_fp[i];
            end
        end
    end

    // GPR x0 results are consumed but never reach the register file.
    assign win_x0 = !win_fp && (win_rd == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_i <= 1'b0;
            write_reg   <= '0;
            write_data  <= '0;
            FPR_GPR_sel <= 1'b0;
        end else begin
            reg_write_i <= accept && !win_x0;
            if (accept && !win_x0) begin
                write_reg   <= win_rd;
                write_data  <= win_data;
                FPR_GPR_sel <= win_fp;
            end
        end
    end

    logic [NREG-1:0] gpr_pend, fpr_pend;
    logic [NREG-1:0] gpr_set, fpr_set, gpr_clr, fpr_clr;

    always_comb begin
        gpr_set = '0;
        fpr_set = '0;
        gpr_clr = '0;
        fpr_clr = '0;
        if (issue_valid) begin
            if (issue_fp)
                fpr_set[issue_rd] = 1'b1;
            else if (issue_rd != '0)
                gpr_set[issue_rd] = 1'b1;
        end
        if (reg_write_i) begin
            if (FPR_GPR_sel)
                fpr_clr[write_reg] = 1'b1;
            else
                gpr_clr[write_reg] = 1'b1;
        end
    end

    // Set is applied after clear: a same-cycle re-issue belongs to a younger producer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpr_pend <= '0;
            fpr_pend <= '0;
        end else begin
            gpr_pend <= (gpr_pend & ~gpr_clr) | gpr_set;
            fpr_pend <= (fpr_pend & ~fpr_clr) | fpr_set;
        end
    end

    assign stall = (rs1_fp    ? fpr_pend[rs1]    : gpr_pend[rs1])
                 | (rs2_fp    ? fpr_pend[rs2]    : gpr_pend[rs2])
                 | (rd_chk_fp ? fpr_pend[rd_chk] : gpr_pend[rd_chk]);
endmodule
